// File: rtl/bit_permuter.sv
// ---------------------------------------------------------------------------
// bit_permuter
//   Single-stage, valid/ready registered bit permutation unit.
//   The permutation network is purely combinational and feeds one output
//   register, so a result is always available exactly one cycle after the
//   input handshake. Full throughput (one word per cycle) is kept by letting
//   a new word enter in the same cycle the held one leaves.
//
// Parameters
//   WIDTH : data width in bits (multiple of GROUP)
//   GROUP : group size in bits for the group-level modes (>= 2)
//   CNT_W : width of the completed-output-transfer counter
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous active-high reset
//   in_valid  : in_data / in_mode valid this cycle
//   in_ready  : block accepts an input this cycle
//   in_data   : word to permute
//   in_mode   : 00 pass, 01 reverse all bits, 10 reverse group order,
//               11 reverse bits inside each group
//   out_valid : out_data holds a result
//   out_ready : downstream accepts out_data this cycle
//   out_data  : permuted word
//   out_mode  : mode that produced out_data
//   xfer_cnt  : number of completed output transfers (wraps)
// ---------------------------------------------------------------------------
module bit_permuter #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int NGRP = WIDTH / GROUP;

  // Permutation candidates
  logic [WIDTH-1:0] rev_all;
  logic [WIDTH-1:0] rev_grp_order;
  logic [WIDTH-1:0] rev_in_grp;
  logic [WIDTH-1:0] perm;

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev_all
      assign rev_all[gi] = in_data[WIDTH-1-gi];
    end
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      assign rev_grp_order[gi*GROUP +: GROUP] = in_data[(NGRP-1-gi)*GROUP +: GROUP];
      for (gj = 0; gj < GROUP; gj++) begin : g_bit
        assign rev_in_grp[gi*GROUP + gj] = in_data[gi*GROUP + GROUP-1-gj];
      end
    end
  endgenerate

  always_comb begin
    perm = in_data;
    unique case (in_mode)
      2'b00: perm = in_data;
      2'b01: perm = rev_all;
      2'b10: perm = rev_grp_order;
      2'b11: perm = rev_in_grp;
      default: perm = in_data;
    endcase
  end

  // Output register state
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic in_hs;
  logic out_hs;

  // The slot can take a new word when empty or when it empties this cycle.
  assign in_ready = (~valid_q | out_ready) & ~reset;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (in_hs) begin
      // New word replaces the held one (also covers the simultaneous case).
      valid_d = 1'b1;
      data_d  = perm;
      mode_d  = in_mode;
    end else if (out_hs) begin
      // Data and mode are left untouched so the last result stays visible.
      valid_d = 1'b0;
    end
    if (out_hs) begin
      cnt_d = cnt_q + 1'b1;  // natural wrap at 2^CNT_W
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_bit_permuter.sv
// ---------------------------------------------------------------------------
// tb_bit_permuter
//   Directed, table-driven bench for bit_permuter (WIDTH=32, GROUP=8,
//   CNT_W=16). Expected words are hand-computed constants; handshake
//   bookkeeping (expected out_valid and transfer count) is tracked by a small
//   bench-side model updated at each clock edge.
// ---------------------------------------------------------------------------
module tb_bit_permuter;

  localparam int WIDTH = 32;
  localparam int GROUP = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] xfer_cnt;

  bit_permuter #(.WIDTH(WIDTH), .GROUP(GROUP), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bench-side handshake model
  logic             m_valid;
  logic [CNT_W-1:0] m_cnt;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; model is updated from the bench's own view of the
  // handshake, then outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic m_in_hs;
    logic m_out_hs;
    m_in_hs  = in_valid & (~m_valid | out_ready) & ~reset;
    m_out_hs = m_valid & out_ready & ~reset;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      if (m_in_hs)       m_valid = 1'b1;
      else if (m_out_hs) m_valid = 1'b0;
      if (m_out_hs)      m_cnt = m_cnt + 1'b1;
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0001, 2'b01, 32'h8000_0000};
    vecs[1] = '{32'h1234_5678, 2'b10, 32'h7856_3412};
    vecs[2] = '{32'h1234_5678, 2'b11, 32'h482C_6A1E};
    vecs[3] = '{32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF};
    vecs[4] = '{32'hDEAD_BEEF, 2'b01, 32'hF77D_B57B};
    vecs[5] = '{32'hDEAD_BEEF, 2'b10, 32'hEFBE_ADDE};
    vecs[6] = '{32'hDEAD_BEEF, 2'b11, 32'h7BB5_7DF7};
    vecs[7] = '{32'h0000_FF01, 2'b10, 32'h01FF_0000};

    m_valid   = 1'b0;
    m_cnt     = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h5555_AAAA;
    in_mode   = 2'b11;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);

    // Table: back-to-back words with out_ready=1, first word in the first
    // cycle after reset.
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      in_mode  = vecs[i].mode;
      #1;
      chk("tbl_in_ready", in_ready, 1);
      tick();
      chk("tbl_out_data", out_data, vecs[i].exp);
      chk("tbl_out_mode", out_mode, vecs[i].mode);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_xfer_cnt", xfer_cnt, m_cnt);
      $display("vec %0d: in=0x%08h mode=%0d -> out=0x%08h (exp 0x%08h) cnt=%0d",
               i, vecs[i].din, vecs[i].mode, out_data, vecs[i].exp, xfer_cnt);
    end
    // Drain last word: transfers, valid clears, data holds.
    in_valid = 1'b0;
    in_data  = 32'h0F0F_0F0F;
    tick();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_data", out_data, 32'h01FF_0000);
    chk("drain_xfer_cnt", xfer_cnt, 8);
    $display("drain: out_valid=%0d out_data=0x%08h cnt=%0d", out_valid, out_data, xfer_cnt);

    // Ignored input while idle
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    in_mode  = 2'b01;
    tick();
    chk("idle_out_data", out_data, 32'h01FF_0000);
    chk("idle_out_valid", out_valid, 0);

    // Backpressure: load A, then hold it for 5 cycles while B is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001;
    in_mode   = 2'b00;
    tick();
    chk("bp_load_data", out_data, 32'hA5A5_0001);
    in_data = 32'h0102_0304;
    in_mode = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold_data", out_data, 32'hA5A5_0001);
      chk("bp_hold_mode", out_mode, 2'b00);
      chk("bp_hold_valid", out_valid, 1);
      $display("bp cycle %0d: in_ready=%0d out_data=0x%08h", c, in_ready, out_data);
    end
    chk("bp_hold_cnt", xfer_cnt, 8);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    chk("bp_new_data", out_data, 32'h0403_0201);
    chk("bp_new_mode", out_mode, 2'b10);
    chk("bp_new_valid", out_valid, 1);
    chk("bp_cnt", xfer_cnt, 9);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_drain_cnt", xfer_cnt, 10);
    chk("bp_drain_data", out_data, 32'h0403_0201);
    $display("bp release: out_data=0x%08h cnt=%0d", out_data, xfer_cnt);

    // Counter wrap: stream until 65535 transfers, then one more.
    in_valid  = 1'b1;
    in_data   = 32'h0000_00FF;
    in_mode   = 2'b01;
    out_ready = 1'b1;
    for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) tick();
    chk("wrap_budget", m_cnt, 16'hFFFF);
    chk("wrap_pre_cnt", xfer_cnt, 16'hFFFF);
    tick();
    chk("wrap_cnt", xfer_cnt, 0);
    chk("wrap_data", out_data, 32'hFF00_0000);
    $display("wrap: xfer_cnt=%0d", xfer_cnt);

    // Reset while a result is held under backpressure.
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_F00D;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    tick();
    chk("rst2_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst2_in_ready_during", in_ready, 0);
    tick();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_xfer_cnt", xfer_cnt, 0);
    chk("rst2_in_ready_held", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst2_in_ready_after", in_ready, 1);
    tick();
    chk("rst2_first_valid", out_valid, 1);
    chk("rst2_first_data", out_data, 32'hCAFE_F00D);
    $display("post-reset: out_valid=%0d out_data=0x%08h", out_valid, out_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
